// File: rtl/wishbone_block_copy_master_pkg.sv
// ---------------------------------------------------------------------------
// wishbone_block_copy_master_pkg
// Shared definitions for the Wishbone block-copy master:
//   state_t       - copy FSM states (IDLE, RD, GAP_RD, WR, GAP_WR, FIN)
//   WB_SEL_ALL    - full-word byte select
//   WB_WORD_INCR  - byte stride between consecutive 32-bit words
//   word_align()  - clears address bits [1:0]
// ---------------------------------------------------------------------------
package wishbone_block_copy_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP_RD,
        ST_WR,
        ST_GAP_WR,
        ST_FIN
    } state_t;

    localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
    localparam logic [31:0] WB_WORD_INCR = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] adr);
        return adr & ~32'h3;
    endfunction

endpackage

// File: rtl/wishbone_block_copy_master_if.sv
// ---------------------------------------------------------------------------
// wishbone_block_copy_master_if
// Wishbone B3 classic 32-bit bus bundle. Signal names follow the master's
// point of view (_o driven by the master, _i driven by the slave).
//   master modport: drives adr/dat_o/sel/we/cyc/stb, receives dat_i/ack/err
//   slave modport : the mirror image
// ---------------------------------------------------------------------------
interface wishbone_block_copy_master_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/wishbone_master_timeout_counter.sv
// ---------------------------------------------------------------------------
// wishbone_master_timeout_counter
// Counts cycles a strobe has been outstanding and flags expiry.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : restart the count (asserted on the edge entering RD/WR)
//   i_en         : strobe currently high
//   o_expired    : high during the TIMEOUT_CYCLES-th strobe cycle, so the
//                  owner aborts on that edge
// Only compiled when WB_MASTER_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
`ifdef WB_MASTER_TIMEOUT_EN
module wishbone_master_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/wishbone_block_copy_master.sv
// ---------------------------------------------------------------------------
// wishbone_block_copy_master
// Wishbone B3 classic master copying count_i 32-bit words from src_adr_i to
// dst_adr_i, one single read cycle then one single write cycle per word.
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   start_i, src_adr_i,
//   dst_adr_i, count_i         : command (sampled only when idle)
//   busy_o, done_o             : command in progress / one-cycle completion
//   err_o, err_adr_o           : sticky abort flag and failing address
//   timeout_o                  : sticky timeout flag (WB_MASTER_TIMEOUT_EN)
//   wb                         : Wishbone master modport
// Optional feature macro: WB_MASTER_TIMEOUT_EN adds a per-strobe timeout
// of TIMEOUT_CYCLES cycles, treated like wb_err_i.
// ---------------------------------------------------------------------------
module wishbone_block_copy_master
    import wishbone_block_copy_master_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_adr_i,
    input  logic [31:0]          dst_adr_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          err_adr_o,
`ifdef WB_MASTER_TIMEOUT_EN
    output logic                 timeout_o,
`endif
    wishbone_block_copy_master_if.master wb
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [31:0]          r_err_adr;
    logic [31:0]          r_adr;
    logic [31:0]          r_dat;
    logic                 r_we;
    logic                 r_cyc;
    logic                 r_stb;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_tmo_expired;

`ifdef WB_MASTER_TIMEOUT_EN
    logic r_timeout;
    logic w_tmo_clr;

    // Clear on the same edge that raises the strobe for a new RD or WR.
    assign w_tmo_clr = (r_state == ST_GAP_RD) || (r_state == ST_GAP_WR) ||
                       ((r_state == ST_IDLE) && start_i && (count_i != '0));

    wishbone_master_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_clr    (w_tmo_clr),
        .i_en     (r_stb),
        .o_expired(w_tmo_expired)
    );

    assign timeout_o = r_timeout;
`else
    assign w_tmo_expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_adr <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_count   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            // Abort path shared by RD and WR; err outranks a coincident ack.
            if (((r_state == ST_RD) || (r_state == ST_WR)) &&
                (wb.wb_err_i || w_tmo_expired)) begin
                r_cyc     <= 1'b0;
                r_stb     <= 1'b0;
                r_we      <= 1'b0;
                r_err     <= 1'b1;
                r_err_adr <= r_adr;
`ifdef WB_MASTER_TIMEOUT_EN
                r_timeout <= !wb.wb_err_i;
`endif
                r_state   <= ST_FIN;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i) begin
                            if (count_i != '0) begin
                                r_src     <= word_align(src_adr_i);
                                r_dst     <= word_align(dst_adr_i);
                                r_count   <= count_i;
                                r_err     <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
                                r_timeout <= 1'b0;
`endif
                                r_busy    <= 1'b1;
                                r_adr     <= word_align(src_adr_i);
                                r_we      <= 1'b0;
                                r_cyc     <= 1'b1;
                                r_stb     <= 1'b1;
                                r_state   <= ST_RD;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_RD: begin
                        if (wb.wb_ack_i) begin
                            r_dat   <= wb.wb_dat_i;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_state <= ST_GAP_RD;
                        end
                    end
                    ST_GAP_RD: begin
                        r_adr   <= r_dst;
                        r_we    <= 1'b1;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= ST_WR;
                    end
                    ST_WR: begin
                        if (wb.wb_ack_i) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_src   <= r_src + WB_WORD_INCR;
                            r_dst   <= r_dst + WB_WORD_INCR;
                            r_count <= r_count - CNT_WIDTH'(1);
                            r_state <= (r_count == CNT_WIDTH'(1)) ? ST_FIN : ST_GAP_WR;
                        end
                    end
                    ST_GAP_WR: begin
                        r_adr   <= r_src;
                        r_we    <= 1'b0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= ST_RD;
                    end
                    ST_FIN: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign err_adr_o   = r_err_adr;
    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_sel_o = WB_SEL_ALL;
    assign wb.wb_we_o  = r_we;
    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_stb;

endmodule

// File: doc/wishbone_block_copy_master.md
Name: wishbone_block_copy_master

Overview:
- Wishbone B3 classic 32-bit master that copies a block of 32-bit words from a source address range to a destination address range.
- Each word is one single read cycle followed by one single write cycle.
- It drives the team's Wishbone slaves (RAMs, peripherals) from test benches and boot logic, for example to relocate firmware or scrub memory.
- A simple start/busy/done command interface sits on the control side; error status is reported back.

Parameters:
- CNT_WIDTH, 16, width of the word-count input; up to 2^CNT_WIDTH-1 words per command.
- TIMEOUT_CYCLES, 256, cycles to wait for ack/err before aborting. Used only when the optional feature is compiled in.

Ports:
- wb_clk_i  input  1  single clock for everything.
- wb_rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  command strobe; sampled only in IDLE.
- src_adr_i  input  32  source byte address; bits [1:0] ignored.
- dst_adr_i  input  32  destination byte address; bits [1:0] ignored.
- count_i  input  CNT_WIDTH  number of 32-bit words to copy.
- busy_o  output  1  high from the cycle after an accepted start until done_o.
- done_o  output  1  one-cycle completion pulse, on success or abort.
- err_o  output  1  sticky abort flag; cleared by the next accepted start.
- err_adr_o  output  32  address of the failing transfer; valid while err_o is high.
- wb_adr_o  output  32  Wishbone address; bits [1:0] always 0.
- wb_dat_o  output  32  write data.
- wb_dat_i  input  32  read data.
- wb_sel_o  output  4  byte selects; constant 4'hF.
- wb_we_o  output  1  write enable.
- wb_cyc_o  output  1  cycle.
- wb_stb_o  output  1  strobe.
- wb_ack_i  input  1  slave acknowledge.
- wb_err_i  input  1  slave error.

Behaviour:
- Interface: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high. All outputs are registered.
- Reset values: busy_o, done_o, err_o, wb_cyc_o, wb_stb_o and wb_we_o are 0; err_adr_o, wb_adr_o and wb_dat_o are 0; wb_sel_o is 4'hF.
- Reset mid-transfer: cyc/stb drop at that edge, the FSM returns to IDLE, no done pulse is issued, and any partial copy is left as is.
- IDLE:
  - start_i=1 with count_i!=0: latch the source and destination addresses (bits [1:0] forced to 0) and the count; clear err_o; set busy_o; go to RD.
  - start_i=1 with count_i=0: pulse done_o on the next cycle with no bus activity; busy_o stays 0.
- RD: cyc=stb=1, we=0, adr=source pointer.
  - On ack: latch wb_dat_i into the word buffer, drop cyc/stb, go to GAP_RD.
- GAP_RD: cyc=stb=0 for exactly one cycle, then go to WR.
- WR: cyc=stb=1, we=1, adr=destination pointer, dat=buffer.
  - On ack: drop cyc/stb, add 4 to both pointers, decrement the count.
  - If the count reaches 0, go to FIN; otherwise go to GAP_WR.
- GAP_WR: one idle cycle, then go to RD.
- FIN: done_o=1 and busy_o=0 for one cycle, then go to IDLE.
- wb_err_i in RD or WR: drop cyc/stb, set err_o=1, set err_adr_o to the current wb_adr_o, go to FIN.
- ack and err in the same cycle: err wins.
- ack/err seen outside RD/WR: ignored.
- Pointer arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- start_i while busy is ignored.
- Latency: against a slave that acks in the cycle after the strobe is sampled (the team's RAMs), each word takes 6 cycles.
  - N words take start edge + 6N cycles, plus the FIN cycle.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears when entering RD or WR and increments every cycle while stb is high.
  - When it reaches TIMEOUT_CYCLES with no ack/err, the block aborts exactly as for wb_err_i.
  - Extra output port timeout_o (1 bit) is set together with err_o and is sticky likewise.
- Not defined:
  - The block waits indefinitely for ack/err.
  - There is no timeout_o port and no counter logic.

Decomposition:
- Shared include file holds:
  - FSM state encodings (IDLE, RD, GAP_RD, WR, GAP_WR, FIN).
  - WB_SEL_ALL = 4'hF.
  - WB_WORD_INCR = 4.
- Sub-module wishbone_master_timeout_counter: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES. Instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Copy 4 words from src 0x000 to dst 0x100, with the RAM preloaded 0x11111111..0x44444444:
  - dst words match, done_o pulses once, err_o=0.
  - Total 25 cycles from start to done.
  - cyc low exactly one cycle between transfers.
- count_i=0 with start_i: done_o pulses on the next cycle; cyc_o never rises; busy_o stays 0.
- Slave asserts wb_err_i on the write to 0x0000_2000 (out of bounds, ADR_WIDTH=11):
  - err_o=1, err_adr_o=0x0000_2000, done_o pulses.
  - No further bus cycles occur.
- src 0xFFFF_FFFC with count 2: the second read is issued at 0x0000_0000 (wrap); destination gets both words.
- Assert wb_rst_i during the WR of word 3 of 8: cyc/stb drop at the next edge, outputs take reset values, no done_o; a new start then works normally.
- With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a slave that never acks: abort 16 cycles after stb rises; err_o=1, timeout_o=1, done_o pulses.
